// File: rtl/tinyqv_uart_pkg.sv
// Shared constants and types for the TinyQV UART peripheral.
package tinyqv_uart_pkg;

    // Register select values (data_addr[3:2]).
    localparam logic [1:0] TXDATA  = 2'd0;
    localparam logic [1:0] RXDATA  = 2'd1;
    localparam logic [1:0] STATUS  = 2'd2;
    localparam logic [1:0] DIVIDER = 2'd3;

    // STATUS bit positions.
    localparam int unsigned ST_TX_BUSY      = 0;
    localparam int unsigned ST_TX_FULL      = 1;
    localparam int unsigned ST_RX_VALID     = 2;
    localparam int unsigned ST_RX_OVERRUN   = 3;
    localparam int unsigned ST_RX_FRAME_ERR = 4;

    localparam int unsigned DIV_W       = 16;
    localparam logic [15:0] DIVIDER_MIN = 16'd4;

    // Shared TX/RX framing state.
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // Smallest usable bit period; shorter values would break the RX mid-bit sample.
    function automatic logic [DIV_W-1:0] clamp_divider(input logic [DIV_W-1:0] d);
        return (d < DIVIDER_MIN) ? DIVIDER_MIN : d;
    endfunction

endpackage

// File: rtl/tinyqv_uart_rx.sv
// 8N1 receiver with 2-flop synchroniser and a one-entry holding register.
module tinyqv_uart_rx
    import tinyqv_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_rxd,
    input  logic [DIV_W-1:0] i_divider,
    input  logic             i_clr_valid,
    input  logic             i_clr_err,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_overrun,
    output logic             o_frame_err
);

    logic             r_sync1, r_sync2, r_prev;
    uart_state_t      r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_stop_ok, w_stop_bad;
    logic             r_valid, r_overrun, r_frame_err;
    logic [7:0]       r_data;

    // Synchronise the asynchronous line and keep one cycle of history for edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // RX FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // RX FSM next state: half-bit wait in START, then one sample per bit period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            UART_IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_nxt = UART_START;
                    w_cnt_nxt   = (i_divider >> 1) - 16'd1;
                end
            end
            UART_START: begin
                if (r_cnt == '0) begin
                    if (r_sync2) begin
                        w_state_nxt = UART_IDLE;
                    end else begin
                        w_state_nxt = UART_DATA;
                        w_cnt_nxt   = i_divider - 16'd1;
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            UART_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = i_divider - 16'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            UART_STOP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = UART_IDLE;
                    w_stop_ok   = r_sync2;
                    w_stop_bad  = !r_sync2;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = UART_IDLE;
        endcase
    end

    // Holding register; a same-cycle read frees the slot for the arriving byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stop_ok && (!r_valid || i_clr_valid)) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
            end else if (i_clr_valid) begin
                r_valid <= 1'b0;
            end
            if (w_stop_ok && r_valid && !i_clr_valid) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/tinyqv_uart_periph.sv
// TinyQV data-bus UART peripheral: bus decode, registers, TX FIFO and TX FSM.
// The RX path is built only when TINYQV_UART_RX_EN is defined.
module tinyqv_uart_periph
    import tinyqv_uart_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR     = 28'h8000000,
    parameter int unsigned CLK_DIV       = 16,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [27:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic [31:0] data_out,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    localparam int unsigned FIFO_AW = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    logic             w_req, w_wr, w_rd, w_can_complete, w_fire;
    logic [1:0]       w_sel;
    logic             w_push, w_div_wr, w_rx_rd, w_st_rd;
    logic             r_ack_done;
    logic [DIV_W-1:0] r_divider;
    logic [31:0]      w_status;

    logic [7:0]       r_fifo_mem [TX_FIFO_DEPTH];
    logic [CNT_W-1:0] r_wr_ptr, r_rd_ptr, w_fifo_count;
    logic             w_fifo_full, w_fifo_empty;
    logic [7:0]       w_fifo_head;

    uart_state_t      r_tx_state, w_tx_state_nxt;
    logic [DIV_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_bit, w_tx_bit_nxt;
    logic [7:0]       r_tx_shift, w_tx_shift_nxt;
    logic             r_txd, w_txd_nxt, w_tx_pop, w_tx_busy;

    logic             w_rx_valid, w_rx_overrun, w_rx_frame_err;
    logic [7:0]       w_rx_data;
    logic             w_unused;

    // Bus decode and single-shot handshake.
    assign w_sel          = data_addr[3:2];
    assign w_req          = rstn && (data_addr[27:4] == BASE_ADDR[27:4])
                            && ((data_write_n != 2'b11) || (data_read_n != 2'b11));
    assign w_wr           = w_req && (data_write_n != 2'b11);
    assign w_rd           = w_req && (data_read_n != 2'b11);
    assign w_can_complete = !(w_wr && (w_sel == TXDATA) && w_fifo_full);
    assign data_ready     = w_req && !r_ack_done && w_can_complete;
    assign w_fire         = data_ready;
    assign w_push         = w_fire && w_wr && (w_sel == TXDATA);
    assign w_div_wr       = w_fire && w_wr && (w_sel == DIVIDER);
    assign w_rx_rd        = w_fire && w_rd && (w_sel == RXDATA);
    assign w_st_rd        = w_fire && w_rd && (w_sel == STATUS);

    // Ack lockout: one completion per request, released when the master goes idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack_done <= 1'b0;
        end else if (!w_req) begin
            r_ack_done <= 1'b0;
        end else if (w_fire) begin
            r_ack_done <= 1'b1;
        end
    end

    // DIVIDER register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_divider <= DIV_W'(CLK_DIV);
        end else if (w_div_wr) begin
            r_divider <= clamp_divider(data_in[15:0]);
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status                  = '0;
        w_status[ST_TX_BUSY]      = w_tx_busy;
        w_status[ST_TX_FULL]      = w_fifo_full;
        w_status[ST_RX_VALID]     = w_rx_valid;
        w_status[ST_RX_OVERRUN]   = w_rx_overrun;
        w_status[ST_RX_FRAME_ERR] = w_rx_frame_err;
    end

    // Read data mux; zero unless a read is completing.
    always_comb begin
        data_out = '0;
        if (w_fire && w_rd) begin
            case (w_sel)
                RXDATA:  data_out = {23'b0, w_rx_valid, (w_rx_valid ? w_rx_data : 8'h00)};
                STATUS:  data_out = w_status;
                DIVIDER: data_out = {16'b0, r_divider};
                default: data_out = '0;
            endcase
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[FIFO_AW-1:0]] <= data_in[7:0];
        end
    end

    // TX FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (w_tx_pop) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

    assign w_fifo_count = r_wr_ptr - r_rd_ptr;
    assign w_fifo_full  = (w_fifo_count == CNT_W'(TX_FIFO_DEPTH));
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_fifo_head  = r_fifo_mem[r_rd_ptr[FIFO_AW-1:0]];

    // TX FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // TX FSM next state: line value for the next bit is registered at each reload.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_txd_nxt      = r_txd;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            UART_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_state_nxt = UART_START;
                    w_tx_cnt_nxt   = r_divider - 16'd1;
                    w_tx_shift_nxt = w_fifo_head;
                    w_txd_nxt      = 1'b0;
                end
            end
            UART_START: begin
                if (r_tx_cnt == '0) begin
                    w_tx_state_nxt = UART_DATA;
                    w_tx_cnt_nxt   = r_divider - 16'd1;
                    w_tx_bit_nxt   = 3'd0;
                    w_txd_nxt      = r_tx_shift[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            UART_DATA: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_nxt = r_divider - 16'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = UART_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            UART_STOP: begin
                if (r_tx_cnt == '0) begin
                    if (!w_fifo_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_state_nxt = UART_START;
                        w_tx_cnt_nxt   = r_divider - 16'd1;
                        w_tx_shift_nxt = w_fifo_head;
                        w_txd_nxt      = 1'b0;
                    end else begin
                        w_tx_state_nxt = UART_IDLE;
                        w_txd_nxt      = 1'b1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            default: begin
                w_tx_state_nxt = UART_IDLE;
                w_txd_nxt      = 1'b1;
            end
        endcase
    end

    assign w_tx_busy = (r_tx_state != UART_IDLE) || !w_fifo_empty;
    assign uart_txd  = r_txd;

`ifdef TINYQV_UART_RX_EN
    // Optional receive path.
    tinyqv_uart_rx u_rx (
        .clk         (clk),
        .rstn        (rstn),
        .i_rxd       (uart_rxd),
        .i_divider   (r_divider),
        .i_clr_valid (w_rx_rd),
        .i_clr_err   (w_st_rd),
        .o_valid     (w_rx_valid),
        .o_data      (w_rx_data),
        .o_overrun   (w_rx_overrun),
        .o_frame_err (w_rx_frame_err)
    );
    assign w_unused = ^{data_in[31:16], data_addr[1:0]};
`else
    assign w_rx_valid     = 1'b0;
    assign w_rx_data      = 8'h00;
    assign w_rx_overrun   = 1'b0;
    assign w_rx_frame_err = 1'b0;
    assign w_unused       = ^{uart_rxd, data_in[31:16], data_addr[1:0], w_rx_rd, w_st_rd};
`endif

endmodule

// File: tb/tb_tinyqv_uart_periph.sv
// Directed self-checking bench for tinyqv_uart_periph (RX checks under TINYQV_UART_RX_EN).
module tb_tinyqv_uart_periph;

    localparam logic [27:0] BASE = 28'h8000000;
    localparam logic [3:0]  A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_DIV = 4'hC;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [27:0] data_addr = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_in = '0;
    logic        data_ready;
    logic [31:0] data_out;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int mon_div = 8;
    int unsigned mon_q[$];

    tinyqv_uart_periph dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_addr    (data_addr),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_in      (data_in),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .uart_txd     (uart_txd),
        .uart_rxd     (uart_rxd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d, output int waits);
        bit done = 1'b0;
        waits = 0;
        data_addr = BASE | 28'(off);
        data_in = d;
        data_write_n = 2'b10;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (data_ready) done = 1'b1;
            else waits++;
        end
        if (!done) chk("wr_timeout", 32'(data_ready), 32'd1);
        @(posedge clk); #1;
        data_write_n = 2'b11;
        data_addr = '0;
        data_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
        bit done = 1'b0;
        d = 32'hDEAD_BEEF;
        data_addr = BASE | 28'(off);
        data_read_n = 2'b10;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (data_ready) begin
                done = 1'b1;
                d = data_out;
            end
        end
        if (!done) chk("rd_timeout", 32'(data_ready), 32'd1);
        @(posedge clk); #1;
        data_read_n = 2'b11;
        data_addr = '0;
        @(posedge clk); #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        uart_rxd = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (d) @(posedge clk);
            #1;
        end
        uart_rxd = stop;
        repeat (d) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Serial monitor on uart_txd: records {stop, byte} sampled mid-bit.
    initial begin
        logic [7:0] mb;
        logic       ms;
        forever begin
            @(negedge clk);
            if (rstn && uart_txd == 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    mb[i] = uart_txd;
                end
                repeat (mon_div) @(negedge clk);
                ms = uart_txd;
                mon_q.push_back({23'b0, ms, mb});
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  tx_b;
        logic [7:0]  fifo_b [6];
        int          w, cnt, bidx, ph;
        logic        exp_bit;

        fifo_b[0] = 8'h11; fifo_b[1] = 8'h22; fifo_b[2] = 8'h33;
        fifo_b[3] = 8'h44; fifo_b[4] = 8'h5A; fifo_b[5] = 8'hE7;

        // Power-on reset
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_txd", 32'(uart_txd), 32'd1);
        bus_read(A_ST, rd);  chk("rst_status", rd, 32'h0);
        bus_read(A_DIV, rd); chk("rst_divider", rd, 32'd16);
        bus_read(A_TX, rd);  chk("txdata_reads_0", rd, 32'h0);

        // Out-of-window request never completes
        data_addr = 28'h0000100;
        data_read_n = 2'b10;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_ready || data_out != 0) cnt++;
        end
        chk("oow_ready", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        data_read_n = 2'b11;
        data_addr = '0;
        @(posedge clk); #1;

        // Single TX byte at DIVIDER=8
        bus_write(A_DIV, 32'd8, w);
        mon_div = 8;
        mon_q.delete();
        tx_b = 8'h55;
        bus_write(A_TX, {24'b0, tx_b}, w);
        for (int c = 2; c <= 80; c++) begin
            @(negedge clk);
            bidx = (c - 2) / 8;
            ph   = (c - 2) % 8;
            if (bidx == 0) exp_bit = 1'b0;
            else if (bidx == 9) exp_bit = 1'b1;
            else exp_bit = tx_b[bidx-1];
            if (ph == 0 || ph == 7) chk($sformatf("tx_bit%0d_ph%0d", bidx, ph), 32'(uart_txd), 32'(exp_bit));
            @(posedge clk); #1;
        end
        data_addr = BASE | 28'(A_ST);
        data_read_n = 2'b10;
        @(negedge clk);
        chk("st_last_cycle_ready", 32'(data_ready), 32'd1);
        chk("st_last_cycle_busy", data_out, 32'h1);
        chk("tx_stop_end", 32'(uart_txd), 32'd1);
        @(posedge clk); #1;
        data_read_n = 2'b11;
        data_addr = '0;
        @(posedge clk); #1;
        bus_read(A_ST, rd); chk("tx_busy_cleared", rd, 32'h0);

        // FIFO backpressure
        mon_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TX, {24'b0, fifo_b[i]}, w);
            chk($sformatf("fifo_wr%0d_waits", i + 1), 32'(w), 32'd0);
        end
        bus_read(A_ST, rd); chk("fifo_full_status", rd, 32'h3);
        bus_write(A_TX, {24'b0, fifo_b[5]}, w);
        chk("fifo_wr6_stall", 32'(w), 32'd70);
        repeat (460) @(posedge clk);
        #1;
        chk("fifo_frames", 32'(mon_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < mon_q.size()) chk($sformatf("fifo_byte%0d", i + 1), mon_q[i], {23'b0, 1'b1, fifo_b[i]});
        end
        bus_read(A_ST, rd); chk("fifo_drained", rd, 32'h0);

`ifdef TINYQV_UART_RX_EN
        // RX single byte
        send_rx(8'hA3, 1'b1, 8);
        bus_read(A_ST, rd); chk("rx_valid_status", rd, 32'h4);
        bus_read(A_RX, rd); chk("rx_data", rd, 32'h1A3);
        bus_read(A_ST, rd); chk("rx_valid_cleared", rd, 32'h0);
        bus_read(A_RX, rd); chk("rx_empty_read", rd, 32'h0);

        // Overrun
        send_rx(8'hA3, 1'b1, 8);
        send_rx(8'h5C, 1'b1, 8);
        bus_read(A_RX, rd); chk("ovr_first_byte", rd, 32'h1A3);
        bus_read(A_ST, rd); chk("ovr_status", rd, 32'h8);
        bus_read(A_ST, rd); chk("ovr_cleared", rd, 32'h0);

        // Start-bit glitch
        uart_rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        bus_read(A_ST, rd); chk("glitch_status", rd, 32'h0);
        bus_read(A_RX, rd); chk("glitch_rxdata", rd, 32'h0);

        // Framing error
        send_rx(8'h3C, 1'b0, 8);
        bus_read(A_ST, rd); chk("ferr_status", rd, 32'h10);
        bus_read(A_ST, rd); chk("ferr_cleared", rd, 32'h0);
`endif

        // Divider clamp and ack lockout
        bus_write(A_DIV, 32'd2, w);
        bus_read(A_DIV, rd); chk("div_clamp", rd, 32'd4);
        mon_div = 4;
        mon_q.delete();
        data_addr = BASE | 28'(A_TX);
        data_in = 32'h0000_00C3;
        data_write_n = 2'b10;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (data_ready) cnt++;
        end
        @(posedge clk); #1;
        data_write_n = 2'b11;
        data_addr = '0;
        chk("lockout_pulses", 32'(cnt), 32'd1);
        repeat (60) @(posedge clk);
        #1;
        chk("lockout_frames", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) chk("lockout_byte", mon_q[0], 32'h1C3);

        // Reset in the middle of a frame
        bus_write(A_TX, 32'h0, w);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_txd", 32'(uart_txd), 32'd0);
        data_addr = BASE | 28'(A_DIV);
        data_read_n = 2'b10;
        rstn = 1'b0;
        #2;
        chk("reset_txd", 32'(uart_txd), 32'd1);
        chk("reset_ready", 32'(data_ready), 32'd0);
        @(posedge clk); #1;
        data_read_n = 2'b11;
        data_addr = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        bus_read(A_ST, rd);  chk("post_reset_status", rd, 32'h0);
        bus_read(A_DIV, rd); chk("post_reset_divider", rd, 32'd16);
        chk("post_reset_txd", 32'(uart_txd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
